// File: rtl/cnn_pkg.sv
// Shared CNN streaming definitions: default map geometry, common widths and
// the feature-map scan FSM state encoding.
package cnn_pkg;

  localparam int MAP_W_DEF       = 14;
  localparam int MAP_H_DEF       = 14;
  localparam int KERNEL_SIZE_DEF = 3;
  localparam int ADDR_W_DEF      = 8;
  localparam int PX_W            = 8;
  localparam int COORD_W         = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

endpackage

// File: rtl/fm_pos_counter.sv
// Row-major pixel position tracker. row/col name the pixel that is being
// presented while en is high; wrap flags the final pixel of the map.
module fm_pos_counter
  import cnn_pkg::*;
#(
  parameter int MAP_W = MAP_W_DEF,
  parameter int MAP_H = MAP_H_DEF,
  parameter int CNT_W = COORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic             wrap,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(MAP_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(MAP_H - 1);

  assign wrap = en && (row == ROW_LAST) && (col == COL_LAST);

  // Advance col on every enabled pixel, stepping row when col wraps.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fm_streamer.sv
// Feature-map streamer: scans a MAP_W x MAP_H map out of an external
// one-cycle-latency RAM in row-major order, feeds each pixel to a line
// buffer and flags when the KxK taps hold a complete in-map window.
module fm_streamer
  import cnn_pkg::*;
#(
  parameter int MAP_W       = MAP_W_DEF,
  parameter int MAP_H       = MAP_H_DEF,
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  output logic               ram_en,
  output logic [ADDR_W-1:0]  ram_addr,
  input  logic [PX_W-1:0]    ram_data,
  output logic [PX_W-1:0]    px_data,
  output logic               px_en,
  output logic               win_valid,
  output logic [COORD_W-1:0] win_row,
  output logic [COORD_W-1:0] win_col,
  output logic               busy,
  output logic               done
);

  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(MAP_W * MAP_H - 1);
  localparam logic [COORD_W-1:0] K_OFF     = COORD_W'(KERNEL_SIZE - 1);

  scan_state_t        state;
  logic               rd_valid;
  logic               last_win;
  logic               scan_clr;
  logic               pos_wrap;
  logic               win_hit;
  logic [COORD_W-1:0] pos_row;
  logic [COORD_W-1:0] pos_col;

  // Reads issue only while scanning and not held; a held RAM keeps its
  // output, so a pending pixel survives any length of stall.
  assign ram_en   = (state == ST_READ) && !stall;
  assign px_en    = rd_valid && !stall;
  assign px_data  = rd_valid ? ram_data : '0;
  assign scan_clr = (state == ST_IDLE) && start;
  assign win_hit  = px_en && (pos_row >= K_OFF) && (pos_col >= K_OFF);

  fm_pos_counter #(
    .MAP_W(MAP_W),
    .MAP_H(MAP_H),
    .CNT_W(COORD_W)
  ) u_pos (
    .clk (clk),
    .rst (rst),
    .clr (scan_clr),
    .en  (px_en),
    .wrap(pos_wrap),
    .row (pos_row),
    .col (pos_col)
  );

  // Scan sequencing: address generation, busy/done and state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ram_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= ST_READ;
            ram_addr <= '0;
            busy     <= 1'b1;
          end
        end
        ST_READ: begin
          if (!stall) begin
            if (ram_addr == LAST_ADDR) state <= ST_DRAIN;
            else                       ram_addr <= ram_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          // last_win rises together with the final win_valid, so done
          // lands exactly one cycle after it.
          if (last_win) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read-valid tracks the RAM's one-cycle latency and freezes under stall.
  always_ff @(posedge clk) begin
    if (rst)         rd_valid <= 1'b0;
    else if (!stall) rd_valid <= ram_en;
  end

  // Window qualification, registered to line up with the shifted taps.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid <= 1'b0;
      last_win  <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      win_valid <= win_hit;
      last_win  <= pos_wrap;
      if (win_hit) begin
        win_row <= pos_row - K_OFF;
        win_col <= pos_col - K_OFF;
      end
    end
  end

endmodule

// File: tb/tb_fm_streamer.sv
// Scoreboard bench for fm_streamer: expected pixels and window coordinates
// are queued before each scan and consumed as the DUT emits them.
module tb_fm_streamer;

  localparam int N_PX  = 196;
  localparam int N_WD  = 12;
  localparam int N_WIN = 144;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stall;
  logic       ram_en;
  logic [7:0] ram_addr;
  logic [7:0] ram_data = 8'd0;
  logic [7:0] px_data;
  logic       px_en;
  logic       win_valid;
  logic [7:0] win_row;
  logic [7:0] win_col;
  logic       busy;
  logic       done;

  fm_streamer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stall    (stall),
    .ram_en   (ram_en),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .px_data  (px_data),
    .px_en    (px_en),
    .win_valid(win_valid),
    .win_row  (win_row),
    .win_col  (win_col),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Feature RAM model: RAM[i] = i, one cycle read latency, holds when idle.
  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = i[7:0];
  always @(posedge clk) if (ram_en) ram_data <= mem[ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard state: pushed by the driver, consumed by the monitor.
  logic [7:0]  px_q  [$];
  logic [15:0] win_q [$];
  int px_cnt   = 0;
  int win_cnt  = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int px_cyc  [N_PX];
  int win_cyc [N_WIN];
  int start_cyc;

  logic [7:0]  exp_px;
  logic [15:0] exp_win;

  always @(negedge clk) begin
    if (px_en) begin
      check("px_expected", px_q.size() > 0, 1);
      if (px_q.size() > 0) begin
        exp_px = px_q.pop_front();
        check("px_data", px_data, exp_px);
        px_cyc[exp_px] = cyc;
      end
      px_cnt++;
    end
    if (stall) check("px_en_in_stall", px_en, 0);
    if (win_valid) begin
      check("win_expected", win_q.size() > 0, 1);
      if (win_q.size() > 0) begin
        exp_win = win_q.pop_front();
        check("win_row", win_row, exp_win[15:8]);
        check("win_col", win_col, exp_win[7:0]);
        win_cyc[exp_win[15:8] * N_WD + exp_win[7:0]] = cyc;
      end
      win_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_at_done", busy, 0);
    end
    if (rst) begin
      px_q.delete();
      win_q.delete();
    end
  end

  task automatic check_all_zero();
    check("z_ram_en", ram_en, 0);
    check("z_ram_addr", ram_addr, 0);
    check("z_px_en", px_en, 0);
    check("z_px_data", px_data, 0);
    check("z_win_valid", win_valid, 0);
    check("z_win_row", win_row, 0);
    check("z_win_col", win_col, 0);
    check("z_busy", busy, 0);
    check("z_done", done, 0);
  endtask

  // One scan: optional stall burst at a pixel index, stray start, or reset.
  task automatic run_scan(input int stall_pix, input int stall_len,
                          input int restart_at, input int rst_pix,
                          input bit start_stall);
    int  base_px   = px_cnt;
    int  base_win  = win_cnt;
    int  base_done = done_cnt;
    int  stall_left = 0;
    bit  stall_used = 1'b0;
    bit  aborted    = 1'b0;
    for (int i = 0; i < N_PX; i++) px_q.push_back(i[7:0]);
    for (int r = 0; r < N_WD; r++)
      for (int c = 0; c < N_WD; c++) win_q.push_back({r[7:0], c[7:0]});

    @(posedge clk); #1;
    start = 1'b1; stall = start_stall; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; stall = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      start = (i == restart_at);
      if (stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end else begin
        stall = 1'b0;
      end
      if (!stall_used && stall_pix >= 0 && (px_cnt - base_px) == stall_pix) begin
        stall      = 1'b1;
        stall_left = stall_len - 1;
        stall_used = 1'b1;
      end
      if (rst_pix >= 0 && (px_cnt - base_px) == rst_pix) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; stall = 1'b0;
        @(negedge clk);
        check_all_zero();
        aborted = 1'b1;
        break;
      end
      if (done_cnt > base_done && cyc > done_cyc + 8) break;
    end
    start = 1'b0;
    stall = 1'b0;

    if (aborted) begin
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("abort_px_count", px_cnt - base_px, rst_pix + 1);
      check("abort_done_count", done_cnt - base_done, 0);
      check("abort_busy", busy, 0);
    end else begin
      check("px_count", px_cnt - base_px, N_PX);
      check("win_count", win_cnt - base_win, N_WIN);
      check("done_count", done_cnt - base_done, 1);
      check("px_q_empty", px_q.size(), 0);
      check("win_q_empty", win_q.size(), 0);
      check("first_px_latency", px_cyc[0] - start_cyc, 2);
      check("first_win_after_px30", win_cyc[0] - px_cyc[30], 1);
      check("done_after_last_win", done_cyc - win_cyc[N_WIN-1], 1);
      check("last_win_after_last_px", win_cyc[N_WIN-1] - px_cyc[N_PX-1], 1);
      check("final_win_row", win_row, 11);
      check("final_win_col", win_col, 11);
      if (stall_pix > 0)
        check("stall_gap", px_cyc[stall_pix] - px_cyc[stall_pix-1], stall_len + 1);
      else
        check("no_stall_gap", px_cyc[N_PX-1] - px_cyc[0], N_PX - 1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_scan(-1, 0, -1, -1, 1'b0);   // plain scan
    run_scan(50, 5, -1, -1, 1'b0);   // stall burst at pixel 50
    run_scan(-1, 0, 20, -1, 1'b0);   // stray start mid-scan
    run_scan(-1, 0, -1, 100, 1'b0);  // reset at pixel 100
    run_scan(-1, 0, -1, -1, 1'b1);   // clean scan after abort, start with stall
    run_scan(195, 3, -1, -1, 1'b0);  // stall on last pixel in drain

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fm_streamer.md
FM_STREAMER -- requirements
Module: fm_streamer

Interface
REQ-001 Parameter MAP_W, default 14, feature-map width in pixels.
REQ-002 Parameter MAP_H, default 14, feature-map height in pixels.
REQ-003 Parameter KERNEL_SIZE, default 3, window edge length.
REQ-004 Parameter ADDR_W, default 8, feature RAM address width.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1, sole clock; all logic on rising edge.
REQ-007 Port rst, input, 1, synchronous active-high reset.
REQ-008 Port start, input, 1, single-cycle pulse that begins one map scan.
REQ-009 Port stall, input, 1, downstream hold; freezes the scan while high.
REQ-010 Port ram_en, output, 1, feature RAM read enable.
REQ-011 Port ram_addr, output, ADDR_W, feature RAM read address, row-major.
REQ-012 Port ram_data, input, 8, RAM read data, valid one cycle after ram_en.
REQ-013 Port px_data, output, 8, pixel to the line buffer in_data.
REQ-014 Port px_en, output, 1, shift enable to the line buffer en.
REQ-015 Port win_valid, output, 1, line-buffer 3x3 taps hold a complete in-map window.
REQ-016 Port win_row / win_col, output, 8 each, top-left coordinate of the current window.
REQ-017 Port busy, output, 1, high from accepted start until done.
REQ-018 Port done, output, 1, one-cycle pulse at scan completion.

Function
REQ-019 FSM states: IDLE, READ, DRAIN, DONE; IDLE -> READ on start; READ -> DRAIN after address MAP_W*MAP_H-1 issued; DRAIN -> DONE after last win_valid; DONE -> IDLE unconditionally.
REQ-020 In READ, ram_en SHALL equal !stall; ram_addr increments by 1 per issued read, starting at 0.
REQ-021 A read-valid register SHALL capture ram_en; it updates only when stall is low.
REQ-022 px_en SHALL equal read-valid AND !stall; px_data SHALL equal ram_data (RAM output holds while ram_en low).
REQ-023 Pixel row/col counters SHALL advance on each px_en, col wrapping MAP_W-1 -> 0 with row increment.
REQ-024 win_valid SHALL be registered: asserted the cycle after a px_en whose pixel has row >= KERNEL_SIZE-1 and col >= KERNEL_SIZE-1, aligned with the updated line-buffer taps.
REQ-025 win_row = row-(KERNEL_SIZE-1), win_col = col-(KERNEL_SIZE-1), registered with win_valid; held otherwise.
REQ-026 Exactly (MAP_W-KERNEL_SIZE+1)*(MAP_H-KERNEL_SIZE+1) win_valid pulses per scan (144 at defaults).
REQ-027 done SHALL pulse in the cycle after the final win_valid; busy deasserts in that same cycle.
REQ-028 start while busy SHALL be ignored; start and stall simultaneous in IDLE SHALL still be accepted.
REQ-029 Stall during DRAIN SHALL delay the final px_en; no pixel dropped or duplicated.
REQ-030 Line-buffer content is not cleared between scans; windows of a new scan are qualified only by the new counters.

Reset
REQ-031 rst SHALL force IDLE; ram_en, px_en, win_valid, busy, done = 0; ram_addr, px_data, win_row, win_col, counters = 0.
REQ-032 rst mid-scan SHALL abort immediately with no further px_en or done.
REQ-033 rst SHALL take priority over start and stall in the same cycle.

Structure
REQ-034 MAP_W, MAP_H, KERNEL_SIZE defaults and FSM state encodings SHALL live in a shared package cnn_pkg.
REQ-035 Row/col position tracking SHALL be one sub-module fm_pos_counter (en, wrap, row, col outputs).
REQ-036 Implementation SHALL be 120-400 lines; no RAM inside the block.

Verification
REQ-037 Reset then start with RAM[i]=i, no stall -> 196 px_en with px_data 0..195 in order, first px_en 2 cycles after start.
REQ-038 Same scan -> first win_valid with win_row=0, win_col=0 one cycle after pixel 30; 144 win_valid total; done one cycle after last (win_row=11, win_col=11).
REQ-039 Stall high for 5 cycles at pixel 50 -> px_en low for those 5 cycles, sequence resumes at 50, totals unchanged.
REQ-040 start pulsed at cycle 20 of a scan -> ignored, exactly one done.
REQ-041 rst asserted at pixel 100 -> next cycle all outputs 0, IDLE; new start gives a clean full scan from address 0.
REQ-042 Stall on the last pixel during DRAIN for 3 cycles -> last px_en delayed 3 cycles, done follows final win_valid by one cycle.
